// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the polyphase FIR output engine.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = int'(i) + 1;
        end
        return r;
    endfunction

    // Full-precision width for a TAPS-term sum of signed products.
    function automatic int acc_width(input int w_in, input int c_in, input int taps);
        return w_in + c_in + clog2(taps);
    endfunction

    // Clamp a sign-extended accumulator into the signed range of a yw-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] acc,
                                                    input int unsigned      yw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (yw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
    endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// Registered signed multiply-accumulate with synchronous clear and a
// saturating, load-enabled output register.
module fir_mac_sat
    import fir_pkg::*;
#(
    parameter int W_IN  = 5,
    parameter int C_IN  = 3,
    parameter int ACC_W = 10,
    parameter int Y_OUT = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    load,
    input  logic signed [W_IN-1:0]  a,
    input  logic signed [C_IN-1:0]  b,
    output logic signed [Y_OUT-1:0] y,
    output logic                    sat
);

    logic signed [ACC_W-1:0]     acc;
    logic signed [W_IN+C_IN-1:0] prod;
    logic signed [63:0]          acc_ext;
    logic signed [63:0]          acc_clip;

    // Full-width product and clamped view of the accumulator. When ACC_W fits
    // in Y_OUT the clamp can never engage, so sat stays 0 in that case.
    always_comb begin
        prod     = a * b;
        acc_ext  = 64'(acc);
        acc_clip = saturate(acc_ext, Y_OUT);
    end

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    // Output register: captures the clamped result once, then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= '0;
            sat <= 1'b0;
        end else if (load) begin
            y   <= Y_OUT'(acc_clip);
            sat <= (acc_clip != acc_ext);
        end
    end

endmodule

// File: rtl/fir_phase_mac.sv
// Polyphase FIR output engine: TAPS-deep delay line, loadable coefficients,
// one time-multiplexed MAC pass every DEC-th accepted sample (phase PHASE).
module fir_phase_mac
    import fir_pkg::*;
#(
    parameter  int W_IN  = 5,
    parameter  int C_IN  = 3,
    parameter  int Y_OUT = 12,
    parameter  int TAPS  = 4,
    parameter  int DEC   = 6,
    parameter  int PHASE = 2,
    localparam int AW    = (clog2(TAPS) > 1) ? clog2(TAPS) : 1,
    localparam int ACC_W = acc_width(W_IN, C_IN, TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_IN-1:0]  x_in,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [C_IN-1:0]  coef_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [Y_OUT-1:0] y_out,
    output logic                    out_sat
);

    localparam int              NW      = (clog2(DEC) > 1) ? clog2(DEC) : 1;
    localparam logic [NW-1:0]   N_PHASE = NW'(PHASE);
    localparam logic [NW-1:0]   N_LAST  = NW'(DEC - 1);
    localparam logic [AW-1:0]   K_LAST  = AW'(TAPS - 1);

    state_t                 state;
    logic [AW-1:0]          k;
    logic [NW-1:0]          n;
    logic signed [W_IN-1:0] dl   [TAPS];
    logic signed [C_IN-1:0] coef [TAPS];
    logic                   pend_we;
    logic [AW-1:0]          pend_addr;
    logic signed [C_IN-1:0] pend_data;
    logic                   accept;
    logic                   trigger;
    logic                   coef_ok;
    logic                   handshake;

    assign in_ready = (state == IDLE);

    // Handshake and qualification terms.
    always_comb begin
        accept    = in_valid && (state == IDLE);
        trigger   = accept && (n == N_PHASE);
        coef_ok   = coef_we && (state == IDLE) && (32'(coef_addr) < TAPS);
        handshake = (state == OUT) && out_valid && out_ready;
    end

    // Delay line: shifts on every accepted sample, frozen otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) dl[i] <= '0;
        end else if (accept) begin
            dl[0] <= x_in;
            for (int unsigned i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
        end
    end

    // Coefficient bank. A write coinciding with a trigger is parked and
    // committed at the result handshake, so that pass sees the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) coef[i] <= '0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            if (coef_ok && trigger) begin
                pend_we   <= 1'b1;
                pend_addr <= coef_addr;
                pend_data <= coef_wdata;
            end else if (coef_ok) begin
                coef[coef_addr] <= coef_wdata;
            end
            if (handshake && pend_we) begin
                coef[pend_addr] <= pend_data;
                pend_we         <= 1'b0;
            end
        end
    end

    // Control FSM: phase counter, tap sequencing, registered out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            n         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) n <= (n == N_LAST) ? '0 : n + 1'b1;
                    if (trigger) begin
                        state <= ACC;
                        k     <= '0;
                    end
                end
                ACC: begin
                    if (k == K_LAST) state <= OUT;
                    else             k     <= k + 1'b1;
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fir_mac_sat #(
        .W_IN  (W_IN),
        .C_IN  (C_IN),
        .ACC_W (ACC_W),
        .Y_OUT (Y_OUT)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (trigger),
        .en   (state == ACC),
        .load ((state == OUT) && !out_valid),
        .a    (dl[k]),
        .b    (coef[k]),
        .y    (y_out),
        .sat  (out_sat)
    );

endmodule

// File: tb/tb_fir_phase_mac.sv
// Bench for fir_phase_mac: three instances (defaults, DEC=1, wide saturating)
// checked against a plain-arithmetic reference model.
module tb_fir_phase_mac;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv   [3];
    logic       cwe  [3];
    logic       ordy [3];
    logic [1:0] ca   [3];
    int         xv   [3];
    int         cdv  [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       os   [3];
    logic [11:0] yo  [3];

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int mdl [3][4];
    int mcf [3][4];
    int mn  [3];
    int mdec[3] = '{6, 1, 1};
    int mph [3] = '{2, 0, 0};
    int ymax[3] = '{2047, 2047, 2047};

    fir_phase_mac #(.W_IN(5), .C_IN(3), .Y_OUT(12), .TAPS(4), .DEC(6), .PHASE(2)) dut_def (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .x_in(5'(xv[0])),
        .coef_we(cwe[0]), .coef_addr(ca[0]), .coef_wdata(3'(cdv[0])),
        .out_valid(ov[0]), .out_ready(ordy[0]), .y_out(yo[0]), .out_sat(os[0]));

    fir_phase_mac #(.W_IN(5), .C_IN(3), .Y_OUT(12), .TAPS(4), .DEC(1), .PHASE(0)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .x_in(5'(xv[1])),
        .coef_we(cwe[1]), .coef_addr(ca[1]), .coef_wdata(3'(cdv[1])),
        .out_valid(ov[1]), .out_ready(ordy[1]), .y_out(yo[1]), .out_sat(os[1]));

    fir_phase_mac #(.W_IN(8), .C_IN(8), .Y_OUT(12), .TAPS(4), .DEC(1), .PHASE(0)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .x_in(8'(xv[2])),
        .coef_we(cwe[2]), .coef_addr(ca[2]), .coef_wdata(8'(cdv[2])),
        .out_valid(ov[2]), .out_ready(ordy[2]), .y_out(yo[2]), .out_sat(os[2]));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int rs(input int w);
        return int'($urandom_range((1 << w) - 1, 0)) - (1 << (w - 1));
    endfunction

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            mn[i] = 0;
            for (int t = 0; t < 4; t++) begin
                mdl[i][t] = 0;
                mcf[i][t] = 0;
            end
        end
    endtask

    task automatic wcoef(input int i, input int a, input int d);
        int cnt;
        cnt = 0;
        while (ir[i] !== 1'b1 && cnt < 40) begin @(posedge clk); #1; cnt++; end
        chk("wr_idle", ir[i], 1);
        cwe[i] = 1'b1; ca[i] = 2'(a); cdv[i] = d;
        @(posedge clk); #1;
        cwe[i] = 1'b0;
        mcf[i][a] = d;
    endtask

    // Offer one sample (optionally with a coefficient write in the same cycle),
    // and if the engine goes busy follow the result to out_valid.
    task automatic push(input int i, input int v, input bit dow, input int wa, input int wd,
                        output bit got, output int ye, output int yobs, output int sobs);
        int cnt; bit trig; bit lowok; int acc; int se;
        cnt = 0; got = 0; yobs = 0; sobs = 0; lowok = 1; acc = 0;
        while (ir[i] !== 1'b1 && cnt < 40) begin @(posedge clk); #1; cnt++; end
        chk("accept_ready", ir[i], 1);
        iv[i] = 1'b1; xv[i] = v; cwe[i] = dow; ca[i] = 2'(wa); cdv[i] = wd;
        @(posedge clk); #1;
        iv[i] = 1'b0; cwe[i] = 1'b0;
        trig  = (mn[i] == mph[i]);
        mn[i] = (mn[i] + 1) % mdec[i];
        for (int t = 3; t > 0; t--) mdl[i][t] = mdl[i][t-1];
        mdl[i][0] = v;
        for (int t = 0; t < 4; t++) acc += mcf[i][t] * mdl[i][t];
        ye = (acc > ymax[i]) ? ymax[i] : (acc < -ymax[i] - 1) ? -ymax[i] - 1 : acc;
        se = (ye != acc) ? 1 : 0;
        if (dow) mcf[i][wa] = wd;
        if (ir[i] === 1'b0) begin
            cnt = 0;
            while (ov[i] !== 1'b1 && cnt < 20) begin
                if (ir[i] !== 1'b0) lowok = 0;
                @(posedge clk); #1; cnt++;
            end
            got = (ov[i] === 1'b1);
            if (ir[i] !== 1'b0) lowok = 0;
            chk("busy_in_ready", lowok, 1);
            chk("latency", cnt, 5);
            yobs = $signed(yo[i]);
            sobs = os[i];
            chk("y_out", yobs, ye);
            chk("out_sat", sobs, se);
            if (ordy[i] === 1'b1) begin
                @(posedge clk); #1;
                chk("ov_drop", ov[i], 0);
                chk("idle_again", ir[i], 1);
            end
        end else begin
            chk("idle_no_ov", ov[i], 0);
        end
        chk("trigger", got, trig);
    endtask

    initial begin
        bit g;
        int ye, yob, sob, nres, j, a;
        int tidx[$];

        for (int i = 0; i < 3; i++) begin
            iv[i] = 0; cwe[i] = 0; ordy[i] = 1; ca[i] = '0; xv[i] = 0; cdv[i] = 0;
        end
        mreset();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ov", ov[i], 0);
            chk("rst_y", $signed(yo[i]), 0);
            chk("rst_sat", os[i], 0);
            chk("rst_rdy", ir[i], 1);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero coefficients give zero results
        push(1, 7, 0, 0, 0, g, ye, yob, sob);  chk("zero_a", yob, 0);
        push(1, 3, 0, 0, 0, g, ye, yob, sob);  chk("zero_b", yob, 0);
        push(1, -2, 0, 0, 0, g, ye, yob, sob); chk("zero_c", yob, 0);
        push(1, 5, 0, 0, 0, g, ye, yob, sob);  chk("zero_d", yob, 0);

        // Basic MAC
        for (int t = 0; t < 4; t++) wcoef(1, t, t);
        push(1, 1, 0, 0, 0, g, ye, yob, sob);
        push(1, 2, 0, 0, 0, g, ye, yob, sob);
        push(1, 3, 0, 0, 0, g, ye, yob, sob);
        push(1, 4, 0, 0, 0, g, ye, yob, sob);
        chk("basic_10", yob, 10);

        // Saturation
        for (int t = 0; t < 4; t++) wcoef(2, t, -128);
        for (int s = 0; s < 4; s++) push(2, -128, 0, 0, 0, g, ye, yob, sob);
        chk("sat_hi_y", yob, 2047);
        chk("sat_hi_flag", sob, 1);
        for (int t = 0; t < 4; t++) wcoef(2, t, 1);
        for (int s = 0; s < 4; s++) push(2, -128, 0, 0, 0, g, ye, yob, sob);
        chk("sat_neg_y", yob, -512);
        chk("sat_neg_flag", sob, 0);
        for (int s = 0; s < 6; s++) push(2, rs(8), ($urandom_range(1, 0) == 1), int'($urandom_range(3, 0)), rs(8), g, ye, yob, sob);

        // Decimation
        for (int t = 0; t < 4; t++) wcoef(0, t, rs(3));
        nres = 0;
        for (int s = 0; s < 12; s++) begin
            push(0, rs(5), 0, 0, 0, g, ye, yob, sob);
            if (g) begin nres++; tidx.push_back(s); end
        end
        chk("dec_count", nres, 2);
        chk("dec_idx0", (tidx.size() > 0) ? tidx[0] : -1, 2);
        chk("dec_idx1", (tidx.size() > 1) ? tidx[1] : -1, 8);

        // Random samples with writes, including writes alongside triggers
        for (int t = 0; t < 4; t++) wcoef(1, t, rs(3));
        for (int s = 0; s < 20; s++)
            push(1, rs(5), ($urandom_range(1, 0) == 1), int'($urandom_range(3, 0)), rs(3), g, ye, yob, sob);

        // Backpressure and write lockout
        ordy[0] = 1'b0;
        g = 0; j = 0;
        while (!g && j < 8) begin
            push(0, rs(5), 0, 0, 0, g, ye, yob, sob);
            j++;
        end
        chk("bp_result", g, 1);
        for (int c = 0; c < 10; c++) begin
            a = c % 4;
            cwe[0] = 1'b1; ca[0] = 2'(a); cdv[0] = ((mcf[0][a] + 5) & 7) - 4;
            @(posedge clk); #1;
            chk("bp_valid", ov[0], 1);
            chk("bp_y", $signed(yo[0]), ye);
            chk("bp_sat", os[0], 0);
            chk("bp_rdy", ir[0], 0);
        end
        cwe[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ov", ov[0], 0);
        chk("bp_release_rdy", ir[0], 1);
        @(posedge clk); #1;
        chk("bp_single", ov[0], 0);
        for (int s = 0; s < 6; s++) push(0, rs(5), 0, 0, 0, g, ye, yob, sob);

        // Reset in the middle of a MAC pass
        wcoef(1, 0, 3); wcoef(1, 1, -4); wcoef(1, 2, 2); wcoef(1, 3, 1);
        iv[1] = 1'b1; xv[1] = 5;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        chk("mid_busy", ir[1], 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mreset();
        chk("mid_ov", ov[1], 0);
        chk("mid_rdy", ir[1], 1);
        chk("mid_y", $signed(yo[1]), 0);
        chk("mid_sat", os[1], 0);
        @(posedge clk); #1;
        chk("mid_no_late_ov", ov[1], 0);
        push(1, 9, 0, 0, 0, g, ye, yob, sob);
        chk("mid_after_y", yob, 0);
        for (int t = 0; t < 4; t++) wcoef(1, t, 1);
        push(1, -6, 0, 0, 0, g, ye, yob, sob);
        chk("mid_dl_cleared", yob, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_phase_mac.md
Name: fir_phase_mac

Overview:
Parametrised polyphase FIR output engine for the DWT filter bank. It is the generalised successor to the fixed 4-tap per-phase output blocks. It keeps a TAPS-deep sample delay line and runtime-loadable coefficients. Every DEC-th accepted sample, selected by PHASE, it computes one filter output with a single time-multiplexed MAC. The output is delivered over a valid/ready handshake with optional saturation.

Parameters:
W_IN, 5, signed sample width
C_IN, 3, signed coefficient width
Y_OUT, 12, signed output width
TAPS, 4, filter taps, >=1
DEC, 6, decimation factor, >=1
PHASE, 2, output phase, 0..DEC-1
AW, max(1,clog2(TAPS)), coefficient address width (localparam)
ACC_W, W_IN+C_IN+clog2(TAPS), accumulator width (localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  sample valid
in_ready  out  1  engine can accept a sample
x_in  in  W_IN  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  AW  tap index to write
coef_wdata  in  C_IN  signed coefficient value
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
y_out  out  Y_OUT  signed filter result
out_sat  out  1  y_out was clipped (qualified by out_valid)

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - delay line dl[0..TAPS-1], coef[0..TAPS-1], accumulator, tap index and phase counter n to 0
  - state to IDLE
  - out_valid, y_out and out_sat to 0
  - Reset has priority in every state, including mid-ACC; any partial result is discarded.
- in_ready=1 only in IDLE. A sample is accepted when in_valid & in_ready:
  - dl shifts: dl[0] becomes x_in (newest), dl[i] becomes dl[i-1]
  - n becomes (n+1) mod DEC
- Trigger: an accepted sample with pre-increment n==PHASE moves IDLE->ACC in the same edge.
- ACC lasts exactly TAPS cycles, k=0..TAPS-1. Cycle k does acc += coef[k]*dl[k]:
  - full signed product, W_IN+C_IN bits, sign-extended to ACC_W
  - acc is cleared on entry to ACC
  - delay line is frozen during ACC
- ACC->OUT after the last tap. In OUT:
  - out_valid=1
  - if ACC_W<=Y_OUT: y_out = sign-extended acc, out_sat=0
  - else: acc is clamped to [-2^(Y_OUT-1), 2^(Y_OUT-1)-1], out_sat=1 when clamped
- y_out and out_sat are held stable while out_valid & !out_ready.
- OUT->IDLE on out_valid & out_ready; out_valid drops the next cycle.
- Latency: a trigger sample accepted at edge t gives out_valid high from edge t+TAPS+1.
- Throughput: at most 1 result per TAPS+2 cycles. Non-trigger samples cost 1 cycle each.
- Coefficient writes:
  - take effect only in IDLE with coef_addr<TAPS
  - writes are silently dropped in ACC/OUT or when the address is out of range
  - a write and a sample accept in the same IDLE cycle are both performed; the trigger uses the old coefficients
- Counter n wraps DEC-1 -> 0. DEC=1 gives an output for every sample.
- All arithmetic is two's complement. No rounding, since no fractional bits are dropped.

Decomposition:
- Shared package fir_pkg:
  - clog2 function
  - state encoding IDLE/ACC/OUT
  - acc_width(W_IN,C_IN,TAPS) function
  - saturate(acc, Y_OUT) function
- One sub-module, fir_mac_sat: registered signed multiply-accumulate with clear and a saturating output stage, parametrised by W_IN, C_IN, ACC_W, Y_OUT.
- Delay line, coefficient bank and FSM stay in the top module.

Test Plan:
- Reset/zero: defaults, no coefficient writes, DEC=1, feed 7,3,-2,5 -> each result y_out=0, out_sat=0; after rst, all outputs 0 and in_ready=1.
- Basic MAC: DEC=1, PHASE=0, coef={0,1,2,3}, feed 1,2,3,4 -> fourth result y_out=0*4+1*3+2*2+3*1=10, out_valid exactly 5 cycles after the accept edge.
- Decimation: defaults (DEC=6, PHASE=2), out_ready=1, feed 12 samples -> exactly two results, triggered by sample indices 2 and 8; in_ready low only during those TAPS+2-cycle windows.
- Saturation: W_IN=8, C_IN=8, Y_OUT=12, TAPS=4, DEC=1, all coef=-128, feed four samples of -128 -> y_out=2047, out_sat=1. Then all coef=1 with samples -128 -> y_out=-512, out_sat=0.
- Backpressure and write lockout: hold out_ready=0 for 10 cycles during OUT -> out_valid, y_out and out_sat stable, in_ready=0, coef_we pulses ignored (verified by the next result); release -> one handshake, then IDLE.
- Reset mid-operation: assert rst during ACC cycle k=2 -> next edge state IDLE, out_valid=0, dl and coef cleared, n=0; the next trigger yields y_out=0.
